// File: rtl/conv_seq_ctrl.sv
// Sequential 1-D linear convolution of two N-sample unsigned banks through one
// shared multiply-accumulate, one product term per clock, streamed out on valid/ready.
module conv_seq_ctrl #(
  parameter int DW = 8,
  parameter int N  = 8,
  parameter int AW = $clog2(N),
  parameter int OW = 2*DW + $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            out_data,
  output logic [$clog2(2*N-1)-1:0] out_idx
);
  localparam int NW = $clog2(2*N-1);
  localparam logic [NW-1:0] N_LAST = NW'(2*N-2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [NW-1:0]   n_r, n_s;
  logic [AW-1:0]   k_r, k_s;
  logic [OW-1:0]   acc_r, acc_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            valid_r, valid_s;
  logic [OW-1:0]   data_r, data_s;
  logic [NW-1:0]   idx_r, idx_s;
  logic [DW-1:0]   x_mem [N];
  logic [DW-1:0]   h_mem [N];
  logic [AW-1:0]   h_addr_s;
  logic [2*DW-1:0] prod_s;
  logic [OW-1:0]   sum_s;

  // First k contributing to y[n]: max(0, n-N+1)
  function automatic logic [AW-1:0] kmin(input logic [NW-1:0] n);
    if (n >= NW'(N)) kmin = AW'(n - NW'(N-1));
    else             kmin = {AW{1'b0}};
  endfunction

  // Last k contributing to y[n]: min(n, N-1)
  function automatic logic [AW-1:0] kmax(input logic [NW-1:0] n);
    if (n < NW'(N-1)) kmax = AW'(n);
    else              kmax = AW'(N-1);
  endfunction

  // Sample banks: writable only while idle, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en && (state_r == IDLE)) begin
      if (wr_sel) h_mem[wr_addr] <= wr_data;
      else        x_mem[wr_addr] <= wr_data;
    end
  end

  // Shared multiply-accumulate term x[k]*h[n-k]
  always_comb begin
    h_addr_s = AW'(n_r - NW'(k_r));
    prod_s   = (2*DW)'(x_mem[k_r]) * (2*DW)'(h_mem[h_addr_s]);
    sum_s    = acc_r + OW'(prod_s);
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    n_s     = n_r;
    k_s     = k_r;
    acc_s   = acc_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    valid_s = valid_r;
    data_s  = data_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          n_s     = {NW{1'b0}};
          k_s     = kmin({NW{1'b0}});
          acc_s   = {OW{1'b0}};
          busy_s  = 1'b1;
          state_s = MAC;
        end else begin
          state_s = IDLE;
        end
      end
      MAC: begin
        acc_s = sum_s;
        k_s   = k_r + AW'(1);
        if (k_r == kmax(n_r)) begin
          valid_s = 1'b1;
          data_s  = sum_s;
          idx_s   = n_r;
          state_s = OUT;
        end else begin
          state_s = MAC;
        end
      end
      OUT: begin
        if (out_ready) begin
          valid_s = 1'b0;
          if (n_r == N_LAST) begin
            done_s  = 1'b1;
            state_s = DONE;
          end else begin
            n_s     = n_r + NW'(1);
            acc_s   = {OW{1'b0}};
            k_s     = kmin(n_r + NW'(1));
            state_s = MAC;
          end
        end else begin
          state_s = OUT;
        end
      end
      DONE: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        valid_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      n_r     <= {NW{1'b0}};
      k_r     <= {AW{1'b0}};
      acc_r   <= {OW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= {OW{1'b0}};
      idx_r   <= {NW{1'b0}};
    end else begin
      state_r <= state_s;
      n_r     <= n_s;
      k_r     <= k_s;
      acc_r   <= acc_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      idx_r   <= idx_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_idx   = idx_r;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed table-driven bench for conv_seq_ctrl at default parameters
// (DW=8, N=8, OW=19), plus stall, busy-disturbance and mid-job reset sequences.
module tb_conv_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        start = 1'b0;
  logic        busy, done, out_valid;
  logic        out_ready = 1'b1;
  logic [18:0] out_data;
  logic [3:0]  out_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Bank arrays are packed with element 0 as the rightmost field.
  typedef struct packed {
    logic [7:0][7:0]   x;
    logic [7:0][7:0]   h;
    logic [14:0][18:0] y;
  } vec_t;

  vec_t              tbl [4];
  logic [14:0][18:0] exp_y;

  conv_seq_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic load(input logic [7:0][7:0] xs, input logic [7:0][7:0] hs);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_sel  = (i >= 8);
      wr_addr = 3'(i % 8);
      wr_data = (i < 8) ? xs[i % 8] : hs[i % 8];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Runs one job against exp_y; cycle 1 is the cycle right after the start edge.
  task automatic run_job(input int stall_at, input bit chk_time, input bit disturb);
    int cyc = 0, got = 0, done_cnt = 0, done_cyc = 0, y0_cyc = 0, fall_cyc = 0, stall_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (fall_cyc == 0 && cyc < 300) begin
      if (disturb && cyc == 10) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 8'd99; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      if (stall_at >= 0 && out_valid && out_idx == 4'(stall_at) && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
        check("stall_data", out_data, exp_y[stall_at]);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && y0_cyc == 0) y0_cyc = cyc;
      if (out_valid && out_ready) begin
        check("out_idx", out_idx, got);
        if (got < 15) check("out_data", out_data, exp_y[got]);
        got++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
        check("done_busy", busy, 1);
        check("done_valid", out_valid, 0);
      end
      if (done_cnt > 0 && !busy) fall_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
    check("job_finished", (fall_cyc != 0), 1);
    check("result_count", got, 15);
    check("done_pulses", done_cnt, 1);
    if (chk_time) begin
      check("y0_latency", y0_cyc, 2);
      check("done_latency", done_cyc, 80);
      check("busy_fall", fall_cyc, done_cyc + 1);
    end
    if (stall_at >= 0) check("stall_len", stall_cnt, 5);
  endtask

  initial begin
    int cnt;
    bit seen4;
    // ones * ones
    tbl[0].x = {8{8'd1}};
    tbl[0].h = {8{8'd1}};
    tbl[0].y = {19'd1, 19'd2, 19'd3, 19'd4, 19'd5, 19'd6, 19'd7, 19'd8,
                19'd7, 19'd6, 19'd5, 19'd4, 19'd3, 19'd2, 19'd1};
    // full-scale: y[n] = c(n) * 65025
    tbl[1].x = {8{8'd255}};
    tbl[1].h = {8{8'd255}};
    tbl[1].y = {19'd65025, 19'd130050, 19'd195075, 19'd260100, 19'd325125, 19'd390150,
                19'd455175, 19'd520200, 19'd455175, 19'd390150, 19'd325125, 19'd260100,
                19'd195075, 19'd130050, 19'd65025};
    // impulse x, h = {3,1,4,1,5,9,2,6}
    tbl[2].x = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    tbl[2].h = {8'd6, 8'd2, 8'd9, 8'd5, 8'd1, 8'd4, 8'd1, 8'd3};
    tbl[2].y = {19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0,
                19'd6, 19'd2, 19'd9, 19'd5, 19'd1, 19'd4, 19'd1, 19'd3};
    // x = {1,2,3,0..}, h = {1,1,0..} -> y = 1,3,5,3,0..
    tbl[3].x = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1};
    tbl[3].h = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    tbl[3].y = {19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0,
                19'd0, 19'd0, 19'd0, 19'd3, 19'd5, 19'd3, 19'd1};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      load(tbl[i].x, tbl[i].h);
      exp_y = tbl[i].y;
      run_job(-1, 1'b1, 1'b0);
    end

    // backpressure on y[3]
    load(tbl[1].x, tbl[1].h);
    exp_y = tbl[1].y;
    run_job(3, 1'b0, 1'b0);

    // write + start while busy are ignored; rerun proves the bank is intact
    load(tbl[2].x, tbl[2].h);
    exp_y = tbl[2].y;
    run_job(-1, 1'b1, 1'b1);
    run_job(-1, 1'b1, 1'b0);

    // reset during the MAC phase of y[5]
    load(tbl[0].x, tbl[0].h);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen4 = 1'b0;
    cnt = 0;
    while (!seen4 && cnt < 200) begin
      if (out_valid && out_idx == 4'd4) seen4 = 1'b1;
      @(negedge clk);
      cnt++;
    end
    check("reach_y4", seen4, 1);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst = 1'b0;
    load(tbl[3].x, tbl[3].h);
    exp_y = tbl[3].y;
    run_job(-1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
